// File: rtl/pio_in_debounce_sync.sv
// Input conditioner for the parallel input port: two-flop synchroniser, tick-driven
// per-bit debouncer and registered rise/fall/changed event pulses.
module pio_in_debounce_sync #(
  parameter int unsigned       WIDTH        = 16,
  parameter int unsigned       TICK_DIV     = 50000,
  parameter int unsigned       STABLE_TICKS = 20,
  parameter logic [WIDTH-1:0]  RESET_VAL    = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);

  localparam int unsigned PCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W  = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

  logic [WIDTH-1:0]  sync1;
  logic [WIDTH-1:0]  sync2;
  logic [PCNT_W-1:0] pcnt;
  logic [PCNT_W-1:0] pcnt_next;
  logic              tick_c;
  logic [CNT_W-1:0]  cnt      [WIDTH];
  logic [CNT_W-1:0]  cnt_next [WIDTH];
  logic [WIDTH-1:0]  db_next;

  // With TICK_DIV == 1 pcnt is pinned at 0 and tick_c stays high.
  assign tick_c = (pcnt == PCNT_W'(TICK_DIV - 1));

  // Next-state: prescaler wrap and per-bit debounce counters.
  always_comb begin
    pcnt_next = tick_c ? '0 : pcnt + PCNT_W'(1);
    db_next   = db_out;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
      if (sync2[i] == db_out[i]) begin
        cnt_next[i] = '0;
      end else if (tick_c) begin
        if (cnt[i] == CNT_W'(STABLE_TICKS - 1)) begin
          db_next[i]  = sync2[i];
          cnt_next[i] = '0;
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // State register; pulses are registered alongside the db_out update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= RESET_VAL;
      sync2      <= RESET_VAL;
      pcnt       <= '0;
      db_out     <= RESET_VAL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      changed    <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1      <= raw_in;
      sync2      <= sync1;
      pcnt       <= pcnt_next;
      db_out     <= db_next;
      rise_pulse <= db_next & ~db_out;
      fall_pulse <= ~db_next & db_out;
      changed    <= |(db_next ^ db_out);
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

endmodule

// File: tb/tb_pio_in_debounce_sync.sv
// Directed bench for pio_in_debounce_sync with TICK_DIV=4, STABLE_TICKS=3.
module tb_pio_in_debounce_sync;

  logic        clk;
  logic        reset_n;
  logic [15:0] raw_in;
  logic [15:0] db_out;
  logic [15:0] rise_pulse;
  logic [15:0] fall_pulse;
  logic        changed;

  int unsigned n_pass;
  int unsigned n_total;

  pio_in_debounce_sync #(
    .WIDTH(16), .TICK_DIV(4), .STABLE_TICKS(3), .RESET_VAL(16'h0000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .db_out(db_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    raw_in  = 16'h0000;
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    raw_in  = 16'hFFFF;
    reset_n = 1'b0;
    repeat (3) step();
    n_total++;
    if (db_out !== 16'h0000) $display("FAIL reset_db_out: got %h want 0000", db_out); else n_pass++;
    n_total++;
    if (rise_pulse !== 16'h0000) $display("FAIL reset_rise: got %h want 0000", rise_pulse); else n_pass++;
    n_total++;
    if (fall_pulse !== 16'h0000) $display("FAIL reset_fall: got %h want 0000", fall_pulse); else n_pass++;
    n_total++;
    if (changed !== 1'b0) $display("FAIL reset_changed: got %b want 0", changed); else n_pass++;
    reset_n = 1'b1;
    step();
    n_total++;
    if (db_out !== 16'h0000) $display("FAIL reset_release_db_out: got %h want 0000", db_out); else n_pass++;
  endtask

  task automatic test_clean_edge();
    int n;
    apply_reset();
    raw_in = 16'h0001;
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      n = k;
      if (db_out[0] === 1'b1) break;
      if (k == 30) n = 31;
    end
    n_total++;
    if (n < 11 || n > 14) $display("FAIL clean_latency: got %0d clk want 11..14", n); else n_pass++;
    n_total++;
    if (rise_pulse !== 16'h0001) $display("FAIL clean_rise: got %h want 0001", rise_pulse); else n_pass++;
    n_total++;
    if (changed !== 1'b1) $display("FAIL clean_changed: got %b want 1", changed); else n_pass++;
    n_total++;
    if (fall_pulse !== 16'h0000) $display("FAIL clean_fall: got %h want 0000", fall_pulse); else n_pass++;
    step();
    n_total++;
    if (rise_pulse !== 16'h0000) $display("FAIL clean_rise_width: got %h want 0000", rise_pulse); else n_pass++;
    n_total++;
    if (changed !== 1'b0) $display("FAIL clean_changed_width: got %b want 0", changed); else n_pass++;
    n_total++;
    if (db_out !== 16'h0001) $display("FAIL clean_hold: got %h want 0001", db_out); else n_pass++;
  endtask

  task automatic test_glitch();
    int pulses;
    int n;
    apply_reset();
    pulses = 0;
    raw_in = 16'h0008;
    for (int k = 0; k < 8; k++) begin
      step();
      if (rise_pulse !== 16'h0000 || fall_pulse !== 16'h0000 || changed !== 1'b0) pulses++;
    end
    raw_in = 16'h0000;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rise_pulse !== 16'h0000 || fall_pulse !== 16'h0000 || changed !== 1'b0) pulses++;
    end
    n_total++;
    if (pulses != 0) $display("FAIL glitch_pulses: got %0d want 0", pulses); else n_pass++;
    n_total++;
    if (db_out !== 16'h0000) $display("FAIL glitch_db_out: got %h want 0000", db_out); else n_pass++;
    // A cleared counter means a fresh level needs the full debounce time.
    raw_in = 16'h0008;
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      n = k;
      if (db_out[3] === 1'b1) break;
      if (k == 30) n = 31;
    end
    n_total++;
    if (n < 11 || n > 14) $display("FAIL glitch_cnt_cleared: got %0d clk want 11..14", n); else n_pass++;
  endtask

  task automatic test_multi_bit();
    int chg;
    apply_reset();
    raw_in = 16'hA5A5;
    for (int k = 0; k < 30; k++) begin
      step();
      if (db_out !== 16'h0000) break;
    end
    n_total++;
    if (db_out !== 16'hA5A5) $display("FAIL multi_db_out: got %h want a5a5", db_out); else n_pass++;
    n_total++;
    if (rise_pulse !== 16'hA5A5) $display("FAIL multi_rise: got %h want a5a5", rise_pulse); else n_pass++;
    n_total++;
    if (changed !== 1'b1) $display("FAIL multi_changed: got %b want 1", changed); else n_pass++;
    chg = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (changed === 1'b1) chg++;
    end
    n_total++;
    if (chg != 0) $display("FAIL multi_changed_single: got %0d extra want 0", chg); else n_pass++;
    raw_in = 16'h0000;
    for (int k = 0; k < 30; k++) begin
      step();
      if (db_out !== 16'hA5A5) break;
    end
    n_total++;
    if (db_out !== 16'h0000) $display("FAIL multi_fall_db_out: got %h want 0000", db_out); else n_pass++;
    n_total++;
    if (fall_pulse !== 16'hA5A5) $display("FAIL multi_fall: got %h want a5a5", fall_pulse); else n_pass++;
    n_total++;
    if (rise_pulse !== 16'h0000) $display("FAIL multi_fall_rise: got %h want 0000", rise_pulse); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int n;
    int early;
    apply_reset();
    early = 0;
    raw_in = 16'h0080;
    repeat (6) step();
    reset_n = 1'b0;
    repeat (2) begin
      step();
      if (db_out !== 16'h0000 || rise_pulse !== 16'h0000 || changed !== 1'b0) early++;
    end
    n_total++;
    if (early != 0) $display("FAIL midreset_during: got %0d bad cycles want 0", early); else n_pass++;
    reset_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      n = k;
      if (db_out[7] === 1'b1) break;
      if (k == 30) n = 31;
    end
    n_total++;
    if (n < 11 || n > 14) $display("FAIL midreset_latency: got %0d clk want 11..14", n); else n_pass++;
  endtask

  task automatic test_bounce();
    int rises;
    int falls;
    int chg;
    apply_reset();
    rises = 0;
    falls = 0;
    chg   = 0;
    raw_in = 16'h8000;
    for (int k = 0; k < 40; k++) begin
      if (k != 0 && (k % 3) == 0) raw_in[15] = ~raw_in[15];
      step();
      if (rise_pulse[15] === 1'b1) rises++;
      if (fall_pulse[15] === 1'b1) falls++;
      if (changed === 1'b1) chg++;
    end
    raw_in = 16'h8000;
    for (int k = 0; k < 30; k++) begin
      step();
      if (rise_pulse[15] === 1'b1) rises++;
      if (fall_pulse[15] === 1'b1) falls++;
      if (changed === 1'b1) chg++;
    end
    n_total++;
    if (rises != 1) $display("FAIL bounce_rises: got %0d want 1", rises); else n_pass++;
    n_total++;
    if (falls != 0) $display("FAIL bounce_falls: got %0d want 0", falls); else n_pass++;
    n_total++;
    if (chg != 1) $display("FAIL bounce_changed: got %0d want 1", chg); else n_pass++;
    n_total++;
    if (db_out !== 16'h8000) $display("FAIL bounce_db_out: got %h want 8000", db_out); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset_n = 1'b0;
    raw_in  = 16'h0000;
    test_reset();
    test_clean_edge();
    test_glitch();
    test_multi_bit();
    test_mid_reset();
    test_bounce();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
